core_ctrl_fsm: RTL
==================

// Module: core_ctrl_fsm
// PURPOSE
// - Multi-cycle control sequencer for the RV32 core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB.
// - Consumes the combinational decoder's control outputs (alu_op, mem_read, mem_write, reg_write).
// - Drives the enables for the PC, IR, data memory and register file, plus the memory handshakes.
// - Sits between the instruction/data memory ports and the decoder/ALU/regfile datapath. It owns no datapath.
// PARAMETERS
// - DATA_WIDTH     32  datapath width; sets the perf counter width
// - ALU_OP_INVALID 3'b111  decoder alu_op code meaning "illegal/unknown instruction"
// PORTS
// - clk             in   1  core clock, rising edge
// - rst             in   1  asynchronous, active-high reset
// - run             in   1  1 = allowed to start a new fetch; 0 = park in FETCH with no request
// - imem_req        out  1  instruction fetch request; held until imem_ready
// - imem_ready      in   1  fetch complete; IR data valid this cycle
// - ir_en           out  1  1-cycle pulse: load IR from imem data
// - alu_op          in   3  from decoder
// - mem_read        in   1  from decoder
// - mem_write       in   1  from decoder
// - reg_write       in   1  from decoder
// - dmem_req        out  1  data memory request; held until dmem_ready
// - dmem_we         out  1  1 = store; valid while dmem_req=1
// - dmem_ready      in   1  data access complete; load data valid this cycle
// - rf_we           out  1  1-cycle register-file write strobe
// - pc_en           out  1  1-cycle PC advance strobe; marks instruction retire
// - illegal         out  1  sticky; set on entering TRAP
// - cycle_cnt       out  DATA_WIDTH  free-running cycle count (CTRL_PERF_EN only)
// - instret_cnt     out  DATA_WIDTH  retired-instruction count (CTRL_PERF_EN only)
// BEHAVIOUR
// - Reset (async):
//   - state=FETCH.
//   - All outputs 0, including counters.
//   - Latched controls cleared.
//   - An access in flight is abandoned; dmem_req/imem_req drop immediately.
// - FETCH:
//   - imem_req = run.
//   - On run & imem_ready: ir_en=1 in that cycle, go to DECODE. A same-cycle ready gives a 1-cycle fetch.
//   - run falling while a request is pending: the request is held until imem_ready. No request is abandoned except by reset.
// - DECODE (1 cycle):
//   - Latch alu_op, mem_read, mem_write and reg_write into *_q.
//   - If alu_op==ALU_OP_INVALID, or mem_read&mem_write, go to TRAP. Otherwise go to EXECUTE.
// - EXECUTE (1 cycle):
//   - If mem_read_q|mem_write_q: go to MEM.
//   - Else if reg_write_q: go to WB.
//   - Else: pc_en=1 (retire), go to FETCH.
// - MEM:
//   - dmem_req=1 and dmem_we=mem_write_q, both held stable until dmem_ready.
//   - On dmem_ready: a load goes to WB; a store sets pc_en=1 and goes to FETCH.
// - WB (1 cycle): rf_we=1 and pc_en=1, then go to FETCH.
// - TRAP:
//   - illegal=1 and all strobes 0.
//   - TRAP is absorbing; only rst leaves it. The PC is not advanced, so it still points at the offending instruction.
// - Decoder inputs are only sampled in DECODE. Changes in any other state are ignored.
// - Zero-wait latency (cycles per instruction):
//   - ALU op with write: 4.
//   - Load: 5.
//   - Store: 4.
//   - No-write/no-mem: 3.
// - Each memory wait cycle adds 1.
// - Invariant: at most one of imem_req and dmem_req is high. Each of ir_en, rf_we and pc_en is high at most once per instruction.
// CONFIGURATION
// - CTRL_PERF_EN defined:
//   - cycle_cnt increments every cycle after reset, wrapping modulo 2^DATA_WIDTH. It freezes in TRAP.
//   - instret_cnt increments on every pc_en, also wrapping.
// - CTRL_PERF_EN undefined: the ports and counters are absent. There is no other behavioural difference.
// STRUCTURE
// - core_pkg holds:
//   - typedef enum logic [2:0] ctrl_state_t {FETCH, DECODE, EXECUTE, MEM, WB, TRAP}.
//   - The ALU_OP_INVALID constant, shared with the decoder.
// - A single sub-module, ctrl_perf_counters, holds both counters. It is instantiated only under CTRL_PERF_EN.
// - The FSM uses one always_ff with async rst for state and latched controls. Outputs are combinational from state and handshakes.
// TESTING
// - Bench instantiates decoder + core_ctrl_fsm; IR loaded on ir_en; memories are models with programmable wait states.
// - Load: IR=32'h000AAA83 (lw x21,0(x21)), zero-wait
//   - Trace FETCH,DECODE,EXECUTE,MEM,WB.
//   - dmem_we=0; rf_we and pc_en both high in cycle 5.
// - Store: IR=32'h0150A023 (sw x21,0(x1)), 3 dmem wait states
//   - dmem_req high 4 cycles with dmem_we=1, stable throughout.
//   - rf_we never high; pc_en on the dmem_ready cycle.
// - Illegal: IR=32'hFFFFFFFF, then IR=32'h00000000 after reset
//   - Both enter TRAP after DECODE with illegal=1.
//   - No dmem_req, rf_we or pc_en; held there for 20+ cycles.
// - Park: run=0 → imem_req=0 indefinitely.
//   - run=1 with 2 imem wait states → ir_en on the 3rd request cycle.
//   - Dropping run mid-request does not lower imem_req before ready.
// - Reset mid-MEM: assert rst during a load's dmem wait.
//   - dmem_req falls without waiting for a clock edge.
//   - After release: FETCH, illegal=0, counters=0.
// - Perf (CTRL_PERF_EN): run 10 zero-wait loads back-to-back.
//   - instret_cnt=10 and cycle_cnt=50 at the 10th pc_en.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32 multi-cycle control path.
// Imported by the control sequencer and shared with the instruction decoder.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WB,
    TRAP
  } ctrl_state_t;

  // Decoder alu_op code meaning "illegal/unknown instruction".
  localparam logic [2:0] ALU_OP_INVALID = 3'b111;

  // An instruction is unexecutable if the decoder flags it invalid or asks
  // for a load and a store at the same time.
  function automatic logic decode_is_illegal(
    input logic [2:0] op,
    input logic [2:0] invalid_code,
    input logic       rd,
    input logic       wr
  );
    return (op == invalid_code) || (rd && wr);
  endfunction

endpackage

// File: rtl/ctrl_perf_counters.sv
// ctrl_perf_counters: free-running cycle counter and retired-instruction
// counter for the control sequencer. Both wrap modulo 2^DATA_WIDTH.
module ctrl_perf_counters #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cycle_en,
  input  logic                  i_retire,
  output logic [DATA_WIDTH-1:0] o_cycle_cnt,
  output logic [DATA_WIDTH-1:0] o_instret_cnt
);

  logic [DATA_WIDTH-1:0] r_cycle_cnt;
  logic [DATA_WIDTH-1:0] r_instret_cnt;

  // Count enabled cycles and retire strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (i_cycle_en) begin
        r_cycle_cnt <= r_cycle_cnt + DATA_WIDTH'(1);
      end
      if (i_retire) begin
        r_instret_cnt <= r_instret_cnt + DATA_WIDTH'(1);
      end
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;

endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle control sequencer for the RV32 core.
// Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB and
// drives the PC/IR/regfile strobes plus the imem/dmem handshakes.
// Optional feature: define CTRL_PERF_EN to add cycle_cnt/instret_cnt.
module core_ctrl_fsm #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [2:0]  ALU_OP_INVALID = core_pkg::ALU_OP_INVALID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  imem_req,
  input  logic                  imem_ready,
  output logic                  ir_en,
  input  logic [2:0]            alu_op,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ready,
  output logic                  rf_we,
  output logic                  pc_en,
  output logic                  illegal
`ifdef CTRL_PERF_EN
  ,
  output logic [DATA_WIDTH-1:0] cycle_cnt,
  output logic [DATA_WIDTH-1:0] instret_cnt
`endif
);

  import core_pkg::*;

  ctrl_state_t r_state;
  ctrl_state_t w_next_state;

  logic [2:0] r_alu_op_q;
  logic       r_mem_read_q;
  logic       r_mem_write_q;
  logic       r_reg_write_q;
  logic       r_fetch_pend;

  logic w_imem_req;
  logic w_ir_en;
  logic w_dmem_req;
  logic w_dmem_we;
  logic w_rf_we;
  logic w_pc_en;
  logic w_decode_trap;

  if (DATA_WIDTH == 0) begin : g_bad_width
    $fatal(1, "core_ctrl_fsm: DATA_WIDTH must be non-zero");
  end

  assign w_decode_trap = decode_is_illegal(alu_op, ALU_OP_INVALID, mem_read, mem_write);

  // State register, decoder-control latches and the outstanding-fetch flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH;
      r_alu_op_q    <= '0;
      r_mem_read_q  <= 1'b0;
      r_mem_write_q <= 1'b0;
      r_reg_write_q <= 1'b0;
      r_fetch_pend  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == DECODE) begin
        r_alu_op_q    <= alu_op;
        r_mem_read_q  <= mem_read;
        r_mem_write_q <= mem_write;
        r_reg_write_q <= reg_write;
      end
      // A fetch that was issued but not yet answered stays requested even if
      // run drops, so imem never sees a request withdrawn.
      r_fetch_pend <= (r_state == FETCH) && w_imem_req && !imem_ready;
    end
  end

  // Next-state and combinational strobes from state and handshakes.
  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    w_ir_en      = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_rf_we      = 1'b0;
    w_pc_en      = 1'b0;
    unique case (r_state)
      FETCH: begin
        // rst gating keeps the request low for the whole reset pulse.
        w_imem_req = (run || r_fetch_pend) && !rst;
        if (w_imem_req && imem_ready) begin
          w_ir_en      = 1'b1;
          w_next_state = DECODE;
        end
      end
      DECODE: begin
        w_next_state = w_decode_trap ? TRAP : EXECUTE;
      end
      EXECUTE: begin
        if (r_mem_read_q || r_mem_write_q) begin
          w_next_state = MEM;
        end else if (r_reg_write_q) begin
          w_next_state = WB;
        end else begin
          w_pc_en      = 1'b1;
          w_next_state = FETCH;
        end
      end
      MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = r_mem_write_q;
        if (dmem_ready) begin
          if (r_mem_write_q) begin
            w_pc_en      = 1'b1;
            w_next_state = FETCH;
          end else begin
            w_next_state = WB;
          end
        end
      end
      WB: begin
        w_rf_we      = 1'b1;
        w_pc_en      = 1'b1;
        w_next_state = FETCH;
      end
      TRAP: begin
        w_next_state = TRAP;
      end
      default: begin
        w_next_state = TRAP;
      end
    endcase
  end

  assign imem_req = w_imem_req;
  assign ir_en    = w_ir_en;
  assign dmem_req = w_dmem_req;
  assign dmem_we  = w_dmem_we;
  assign rf_we    = w_rf_we;
  assign pc_en    = w_pc_en;
  // TRAP is absorbing, so the state itself is the sticky flag.
  assign illegal  = (r_state == TRAP);

`ifdef CTRL_PERF_EN
  logic w_cycle_en;
  assign w_cycle_en = (r_state != TRAP);

  ctrl_perf_counters #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_perf (
    .clk          (clk),
    .rst          (rst),
    .i_cycle_en   (w_cycle_en),
    .i_retire     (w_pc_en),
    .o_cycle_cnt  (cycle_cnt),
    .o_instret_cnt(instret_cnt)
  );
`else
  // No performance counters in this build.
`endif

  a_one_mem_req: assert property (@(posedge clk) disable iff (rst)
    !(w_imem_req && w_dmem_req));

  a_latched_op_legal: assert property (@(posedge clk) disable iff (rst)
    (r_state inside {EXECUTE, MEM, WB}) |-> (r_alu_op_q != ALU_OP_INVALID));

endmodule
